// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_pkg : shared types and helpers for the UART receiver              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_rx_pkg;

  // Gray-coded so adjacent states differ in one bit
  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    START_BIT  = 3'b001,
    DATA_BITS  = 3'b011,
    PARITY_BIT = 3'b010,
    STOP_BIT   = 3'b110,
    ERR_CHK    = 3'b111
  } rx_state_e;

  typedef enum logic [5:0] {
    PRESCALE_8  = 6'd8,
    PRESCALE_16 = 6'd16,
    PRESCALE_32 = 6'd32
  } prescale_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_e;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_sampler : three mid-bit samples of RX_IN and a majority vote      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_val,
  output logic                  sample_done
);

  localparam logic [PRESCALE_W-1:0] c_one = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] c_two = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] w_half;
  logic                  w_sample_now;
  logic [2:0]            r_smp;

  assign w_half       = prescale >> 1;
  assign w_sample_now = (edge_cnt == w_half - c_one) ||
                        (edge_cnt == w_half) ||
                        (edge_cnt == w_half + c_one);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_smp <= '0;
    end else if (w_sample_now) begin
      r_smp <= {r_smp[1:0], rx_in};
    end
  end

  // All three samples are registered by the time the count reaches P/2+2
  assign bit_val     = majority3(r_smp);
  assign sample_done = (edge_cnt == w_half + c_two);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx : oversampling UART receiver, optional parity, one-cycle pulses   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0]  c_last_bit = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0]  c_bit_one  = BIT_CNT_W'(1);
  localparam logic [PRESCALE_W-1:0] c_cnt_one  = PRESCALE_W'(1);

  rx_state_e             r_state;
  rx_state_e             w_next_state;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_bit;
  logic                  r_par_flag;
  logic                  r_stp_flag;

  logic                  w_voted;
  logic                  w_sample_done;
  logic                  w_bit_end;
  logic                  w_frame_start;
  logic                  w_exp_par;

  logic [DATA_WIDTH-1:0] w_pdata_nxt;
  logic                  w_dv_nxt;
  logic                  w_pe_nxt;
  logic                  w_se_nxt;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (RX_IN),
    .edge_cnt    (r_edge_cnt),
    .prescale    (r_prescale),
    .bit_val     (w_voted),
    .sample_done (w_sample_done)
  );

  assign w_bit_end     = (r_edge_cnt == r_prescale - c_cnt_one);
  assign w_frame_start = (w_next_state == START_BIT) && (r_state != START_BIT);
  assign w_exp_par     = (^r_shift) ^ (r_par_typ == PAR_ODD);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:       if (!RX_IN) w_next_state = START_BIT;
      START_BIT:  if (w_bit_end) w_next_state = r_bit ? IDLE : DATA_BITS;
      DATA_BITS:  if (w_bit_end && (r_bit_cnt == c_last_bit))
                    w_next_state = r_par_en ? PARITY_BIT : STOP_BIT;
      PARITY_BIT: if (w_bit_end) w_next_state = STOP_BIT;
      STOP_BIT:   if (w_bit_end) w_next_state = ERR_CHK;
      ERR_CHK:    w_next_state = RX_IN ? IDLE : START_BIT;
      default:    w_next_state = IDLE;
    endcase
  end

  // Frame settings are captured on every entry to START_BIT, including back-to-back frames
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_bit      <= 1'b1;
      r_par_flag <= 1'b0;
      r_stp_flag <= 1'b0;
    end else begin
      if (w_sample_done) begin
        r_bit <= w_voted;
      end

      if (w_frame_start) begin
        r_edge_cnt <= c_cnt_one;
        r_prescale <= Prescale;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_bit_cnt  <= '0;
        r_par_flag <= 1'b0;
        r_stp_flag <= 1'b0;
      end else if ((r_state == IDLE) || (r_state == ERR_CHK) || w_bit_end) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + c_cnt_one;
      end

      if ((r_state == DATA_BITS) && w_bit_end) begin
        r_shift   <= {r_bit, r_shift[DATA_WIDTH-1:1]};
        r_bit_cnt <= (r_bit_cnt == c_last_bit) ? '0 : r_bit_cnt + c_bit_one;
      end

      if ((r_state == PARITY_BIT) && w_bit_end) begin
        r_par_flag <= (r_bit != w_exp_par);
      end

      if ((r_state == STOP_BIT) && w_bit_end) begin
        r_stp_flag <= ~r_bit;
      end
    end
  end

  always_comb begin
    w_dv_nxt    = 1'b0;
    w_pe_nxt    = 1'b0;
    w_se_nxt    = 1'b0;
    w_pdata_nxt = P_DATA;
    if (r_state == ERR_CHK) begin
      w_pe_nxt = r_par_flag;
      w_se_nxt = r_stp_flag;
      w_dv_nxt = ~r_par_flag & ~r_stp_flag;
      if (w_dv_nxt) begin
        w_pdata_nxt = r_shift;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;
    end else begin
      P_DATA     <= w_pdata_nxt;
      Data_Valid <= w_dv_nxt;
      Par_err    <= w_pe_nxt;
      Stp_err    <= w_se_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver for the low-power multi-clock communication system, the receive-side counterpart of the UART transmitter in the same clock domain. Oversamples `RX_IN` at `Prescale` ticks per bit, majority-votes each bit, deserializes LSB-first, checks optional parity and the stop bit, and presents a parallel word with a one-cycle valid pulse. Sits in the UART RX clock domain and feeds the register/system controller through the data synchronizer.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `PRESCALE_W`, 6: width of the `Prescale` input.
- `CLK`  in  1  UART RX clock, runs at `Prescale` × baud rate.
- `RST`  in  1  reset, synchronous, active-low.
- `RX_IN`  in  1  serial line, idle high; pre-synchronized upstream.
- `PAR_EN`  in  1  1 = parity bit present after data.
- `PAR_TYP`  in  1  0 = even, 1 = odd parity.
- `Prescale`  in  `PRESCALE_W`  oversampling ratio; legal values 8, 16, 32.
- `P_DATA`  out  `DATA_WIDTH`  last good received word.
- `Data_Valid`  out  1  one-cycle pulse when `P_DATA` is updated.
- `Par_err`  out  1  one-cycle pulse, parity mismatch.
- `Stp_err`  out  1  one-cycle pulse, stop bit sampled low.

## Operation
- States (Gray coded): `IDLE`, `Start_bit`, `Data_bits`, `Parity_bit`, `Stop_bit`, `Err_chk`.
- `edge_cnt`: counts 0..`Prescale`-1 within each bit, clears on wrap. `bit_cnt`: counts data bits 0..`DATA_WIDTH`-1.
- `Prescale`, `PAR_EN`, `PAR_TYP` latched on leaving `IDLE`; changes mid-frame are ignored.
- Sampling: three samples at `edge_cnt` = P/2-1, P/2, P/2+1; bit value = majority. Bit decision is available at `edge_cnt` = P/2+2.
- `IDLE`: `RX_IN`=0 → `Start_bit`, `edge_cnt` set to 1.
- `Start_bit`: at `edge_cnt`=P-1 → `Data_bits` if voted bit is 0; if voted 1 (glitch) → `IDLE` with no output pulse.
- `Data_bits`: voted bit shifted in LSB-first; after bit `DATA_WIDTH`-1 wraps → `Parity_bit` if `PAR_EN`, else `Stop_bit`.
- `Parity_bit`: computes expected parity (XOR of data, inverted for odd); mismatch flag stored; at wrap → `Stop_bit`.
- `Stop_bit`: voted 0 sets stop-error flag; at wrap → `Err_chk`.
- `Err_chk` (one cycle): no errors → `P_DATA` loaded from shift register, `Data_Valid`=1; otherwise `Par_err`/`Stp_err` pulse per flags, `Data_Valid`=0, `P_DATA` unchanged. Next state `Start_bit` with `edge_cnt`=1 if `RX_IN`=0 (back-to-back frame), else `IDLE`.
- Both errors may pulse in the same cycle.

## Timing
- Reset (sync, `RST`=0 at a `CLK` edge): state `IDLE`, counters 0, `P_DATA`=0, `Data_Valid`=`Par_err`=`Stp_err`=0. Reset mid-frame abandons the frame with no pulses.
- All outputs registered; `Data_Valid`/`Par_err`/`Stp_err` high exactly one cycle.
- Latency: falling start edge sampled at cycle 0 → `Err_chk` outputs visible P×(2+`DATA_WIDTH`+`PAR_EN`) cycles later.
- Back-to-back frames with no idle gap are received without loss.
- Illegal `Prescale` values: behaviour undefined, not verified.

## Structure
- Package `uart_rx_pkg`: state enum `rx_state_e`, legal prescale constants, parity-type constants.
- Sub-module `uart_rx_sampler`: takes `RX_IN`, `edge_cnt`, latched prescale; outputs voted bit and `sample_done`.
- Top holds FSM, edge/bit counters, shift register, parity/stop check and output registers.

## Test plan
- `Prescale`=8, `PAR_EN`=0, send 0xA5 → `Data_Valid` pulse, `P_DATA`=0xA5, no errors, pulse 80 cycles after start edge.
- `Prescale`=16, `PAR_EN`=1, `PAR_TYP`=0, send 0x3C with parity 0 → valid; repeat with parity 1 → `Par_err` pulse, `P_DATA` holds 0x3C from before.
- `Prescale`=32, odd parity, stop bit driven low for full bit on 0x81 → `Stp_err` pulse, `Data_Valid`=0.
- Start glitch: `RX_IN` low for 2 ticks at `Prescale`=16 → return to `IDLE`, no pulses; then valid 0x55 received correctly.
- Back-to-back frames 0x01, 0xFE, 0x7F at `Prescale`=8, no idle gap → three `Data_Valid` pulses with those values in order.
- Assert `RST`=0 mid-data of 0xC3, release, send 0x12 → no pulse for aborted frame, `P_DATA`=0x12 afterwards.
